// File: rtl/wb_cpu_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_cpu_bus_arbiter_if
// Bundles the Wishbone signals of the CPU-side arbiter. It has two sides:
//   - NUM_MASTERS master-side request ports (m_*_i) and their terminations
//     (m_*_o). Master k occupies slice k of every packed array.
//   - one shared slave-side port (s_*_o requests, s_*_i responses).
// Modports:
//   slave  : view taken by the arbiter. It is the slave of the CPU masters and
//            drives the shared slave port.
//   master : view taken by the surrounding fabric and CPUs, the mirror image.
// ---------------------------------------------------------------------------
interface wb_cpu_bus_arbiter_if #(
  parameter int NUM_MASTERS   = 2,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  localparam int SEL_W = DATA_WIDTH / 8;

  // master side
  logic [NUM_MASTERS-1:0][ADDRESS_WIDTH-1:0] m_adr_i;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]    m_dat_i;
  logic [NUM_MASTERS-1:0][SEL_W-1:0]         m_sel_i;
  logic [NUM_MASTERS-1:0][2:0]               m_cti_i;
  logic [NUM_MASTERS-1:0][1:0]               m_bte_i;
  logic [NUM_MASTERS-1:0]                    m_we_i;
  logic [NUM_MASTERS-1:0]                    m_stb_i;
  logic [NUM_MASTERS-1:0]                    m_cyc_i;
  logic [DATA_WIDTH-1:0]                     m_dat_o;
  logic [NUM_MASTERS-1:0]                    m_ack_o;
  logic [NUM_MASTERS-1:0]                    m_err_o;
  logic [NUM_MASTERS-1:0]                    m_rty_o;

  // slave side
  logic [ADDRESS_WIDTH-1:0]                  s_adr_o;
  logic [DATA_WIDTH-1:0]                     s_dat_o;
  logic [SEL_W-1:0]                          s_sel_o;
  logic [2:0]                                s_cti_o;
  logic [1:0]                                s_bte_o;
  logic                                      s_we_o;
  logic                                      s_stb_o;
  logic                                      s_cyc_o;
  logic [DATA_WIDTH-1:0]                     s_dat_i;
  logic                                      s_ack_i;
  logic                                      s_err_i;
  logic                                      s_rty_i;

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i, m_we_i, m_stb_i, m_cyc_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o, s_we_o, s_stb_o, s_cyc_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i, m_we_i, m_stb_i, m_cyc_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o, s_we_o, s_stb_o, s_cyc_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i
  );
endinterface

// File: rtl/wb_cpu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// wb_cpu_bus_arbiter
// Wishbone B3 arbiter that merges NUM_MASTERS CPU-side masters onto one
// shared slave port. It supports round-robin or fixed-priority selection and
// has a per-transfer watchdog that ends hung cycles with ERR.
// Ports:
//   clk_i     : system clock
//   rst_i     : asynchronous active-low reset
//   bus       : wb_cpu_bus_arbiter_if.slave, carrying all master and slave
//               Wishbone signals
//   grant_o   : one-hot registered owner (all zero when the bus is free)
//   timeout_o : one-cycle pulse while a watchdog abort is in progress
// ---------------------------------------------------------------------------

// Per-master lane. It masks the master's request fields with its grant bit,
// so the top level can OR-reduce all lanes into the slave request. It also
// routes slave terminations to the master only when that master owns the bus.
module wb_cpu_bus_arbiter_lane #(
  parameter int REQ_W = 8
) (
  input  logic             gnt,
  input  logic             live,     // OWNED: slave terminations pass through
  input  logic             abort,    // ABORT: forced ERR to the owner
  input  logic [REQ_W-1:0] req,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  input  logic             s_rty_i,
  output logic [REQ_W-1:0] req_m,
  output logic             m_ack_o,
  output logic             m_err_o,
  output logic             m_rty_o
);
  assign req_m   = req & {REQ_W{gnt}};
  assign m_ack_o = gnt & live & s_ack_i;
  assign m_rty_o = gnt & live & s_rty_i;
  // A slave ERR that arrives during ABORT is dropped. The forced ERR covers it.
  assign m_err_o = gnt & ((live & s_err_i) | abort);
endmodule

module wb_cpu_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  wb_cpu_bus_arbiter_if.slave     bus,
  output logic [NUM_MASTERS-1:0]  grant_o,
  output logic                    timeout_o
);
  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int IW    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int REQ_W = ADDRESS_WIDTH + DATA_WIDTH + SEL_W + 3 + 2 + 1;
  localparam int WDW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, OWNED, ABORT} state_e;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0]    dat;
    logic [SEL_W-1:0]         sel;
    logic [2:0]               cti;
    logic [1:0]               bte;
    logic                     we;
  } req_t;

  state_e                 state;
  logic [IW-1:0]          own;       // binary form of grant_o
  logic [IW-1:0]          ptr;       // last granted master (round-robin origin)
  logic [WDW-1:0]         wd;

  logic                   live, abort;
  logic                   own_cyc, s_term, wd_inc, wd_hit;
  logic                   win_vld;
  logic [IW-1:0]          win_idx;
  logic [IW:0]            rr_idx;
  logic [NUM_MASTERS-1:0] win_oh;

  logic [NUM_MASTERS-1:0][REQ_W-1:0] req_m;
  logic [REQ_W-1:0]                  req_or;
  req_t                              sreq;
  logic [NUM_MASTERS-1:0]            ack_v, err_v, rty_v;

  assign live    = (state == OWNED);
  assign abort   = (state == ABORT);
  assign own_cyc = bus.m_cyc_i[own];
  assign s_term  = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;

  // Winner search. The loops run backwards so the candidate reached first in
  // search order is the last one assigned. Under round-robin the releasing
  // owner (ptr) comes last, and it has dropped CYC anyway when this result
  // is used for a handover.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    rr_idx  = '0;
    if (PRIORITY_MODE != 0) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (bus.m_cyc_i[i]) begin
          win_vld = 1'b1;
          win_idx = IW'(i);
        end
      end
    end else begin
      for (int k = NUM_MASTERS; k >= 1; k--) begin
        rr_idx = {1'b0, ptr} + (IW+1)'(k);
        if (rr_idx >= (IW+1)'(NUM_MASTERS))
          rr_idx = rr_idx - (IW+1)'(NUM_MASTERS);
        if (bus.m_cyc_i[rr_idx[IW-1:0]]) begin
          win_vld = 1'b1;
          win_idx = rr_idx[IW-1:0];
        end
      end
    end
  end

  always_comb begin
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
  end

  // The watchdog counts stalled strobe edges. A cycle with STB low holds the
  // count, because the transfer is still open until a termination arrives.
  assign wd_inc = (TIMEOUT_CYCLES != 0) && bus.s_stb_o && !s_term;
  assign wd_hit = wd_inc && (wd == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      grant_o   <= '0;
      own       <= '0;
      ptr       <= '0;
      wd        <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          wd <= '0;
          if (win_vld) begin
            grant_o <= win_oh;
            own     <= win_idx;
            ptr     <= win_idx;
            state   <= OWNED;
          end
        end
        OWNED: begin
          if (!own_cyc) begin
            // Release: hand over directly or fall back to IDLE.
            wd <= '0;
            if (win_vld) begin
              grant_o <= win_oh;
              own     <= win_idx;
              ptr     <= win_idx;
            end else begin
              grant_o <= '0;
              state   <= IDLE;
            end
          end else if (wd_hit) begin
            wd        <= '0;
            timeout_o <= 1'b1;
            state     <= ABORT;
          end else if (wd_inc) begin
            wd <= wd + WDW'(1);
          end else if (s_term) begin
            wd <= '0;
          end
        end
        ABORT: begin
          wd <= '0;
          if (own_cyc) begin
            state <= OWNED;
          end else if (win_vld) begin
            grant_o <= win_oh;
            own     <= win_idx;
            ptr     <= win_idx;
            state   <= OWNED;
          end else begin
            grant_o <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          grant_o <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_lane
    wb_cpu_bus_arbiter_lane #(.REQ_W(REQ_W)) u_lane (
      .gnt     (grant_o[k]),
      .live    (live),
      .abort   (abort),
      .req     ({bus.m_adr_i[k], bus.m_dat_i[k], bus.m_sel_i[k],
                 bus.m_cti_i[k], bus.m_bte_i[k], bus.m_we_i[k]}),
      .s_ack_i (bus.s_ack_i),
      .s_err_i (bus.s_err_i),
      .s_rty_i (bus.s_rty_i),
      .req_m   (req_m[k]),
      .m_ack_o (ack_v[k]),
      .m_err_o (err_v[k]),
      .m_rty_o (rty_v[k])
    );
  end

  // Grant is one-hot or zero, so an OR across the masked lanes is the mux.
  always_comb begin
    req_or = '0;
    for (int k = 0; k < NUM_MASTERS; k++) req_or = req_or | req_m[k];
  end
  assign sreq = req_t'(req_or);

  assign bus.s_adr_o = sreq.adr;
  assign bus.s_dat_o = sreq.dat;
  assign bus.s_sel_o = sreq.sel;
  assign bus.s_cti_o = sreq.cti;
  assign bus.s_bte_o = sreq.bte;
  assign bus.s_we_o  = sreq.we;
  assign bus.s_cyc_o = live & own_cyc;
  assign bus.s_stb_o = live & own_cyc & bus.m_stb_i[own];

  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.m_ack_o = ack_v;
  assign bus.m_err_o = err_v;
  assign bus.m_rty_o = rty_v;
endmodule

// File: tb/tb_wb_cpu_bus_arbiter.sv
// Two arbiters share one random stimulus stream: round-robin with an
// 8-cycle watchdog, and fixed priority with the watchdog disabled. A
// transaction-level model predicts the owner, the terminations and the
// slave-side view for every cycle.
module tb_wb_cpu_bus_arbiter;
  localparam int N = 3, AW = 16, DW = 32, SW = DW / 8;

  typedef struct packed {
    logic [N-1:0]  grant;
    logic [N-1:0]  ack;
    logic [N-1:0]  err;
    logic [N-1:0]  rty;
    logic          tmo;
    logic          s_cyc;
    logic          s_stb;
    logic          s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat;
    logic [SW-1:0] s_sel;
    logic [2:0]    s_cti;
    logic [1:0]    s_bte;
    logic [DW-1:0] m_dat;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0][AW-1:0] m_adr;
  logic [N-1:0][DW-1:0] m_dat;
  logic [N-1:0][SW-1:0] m_sel;
  logic [N-1:0][2:0]    m_cti;
  logic [N-1:0][1:0]    m_bte;
  logic [N-1:0]         m_we, m_stb, m_cyc;
  logic [DW-1:0]        s_dat;
  logic                 s_ack, s_err, s_rty;

  logic [1:0][N-1:0]    grant_v;
  logic [1:0]           tmo_v;
  obs_t                 obs [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_cpu_bus_arbiter_if #(.NUM_MASTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    assign bus.m_adr_i = m_adr;
    assign bus.m_dat_i = m_dat;
    assign bus.m_sel_i = m_sel;
    assign bus.m_cti_i = m_cti;
    assign bus.m_bte_i = m_bte;
    assign bus.m_we_i  = m_we;
    assign bus.m_stb_i = m_stb;
    assign bus.m_cyc_i = m_cyc;
    assign bus.s_dat_i = s_dat;
    assign bus.s_ack_i = s_ack;
    assign bus.s_err_i = s_err;
    assign bus.s_rty_i = s_rty;

    wb_cpu_bus_arbiter #(
      .NUM_MASTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
      .PRIORITY_MODE(g), .TIMEOUT_CYCLES((g == 0) ? 8 : 0)
    ) u_dut (
      .clk_i(clk), .rst_i(rst_n), .bus(bus),
      .grant_o(grant_v[g]), .timeout_o(tmo_v[g])
    );

    assign obs[g] = {grant_v[g], bus.m_ack_o, bus.m_err_o, bus.m_rty_o, tmo_v[g],
                     bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o,
                     bus.s_sel_o, bus.s_cti_o, bus.s_bte_o, bus.m_dat_o};
  end

  int checks = 0, errors = 0;
  int n_tmo = 0, n_hand = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference model. Index 0 is round-robin/8, index 1 is fixed/off.
  int owner [2];
  int ptr   [2];
  int wd    [2];
  bit abrt  [2];
  int MODE  [2] = '{0, 1};
  int TMO   [2] = '{8, 0};

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      owner[c] = -1; ptr[c] = 0; wd[c] = 0; abrt[c] = 1'b0;
    end
  endtask

  function automatic int pick(input int c, input logic [N-1:0] req);
    if (req == '0) return -1;
    if (MODE[c] == 1) begin
      for (int i = 0; i < N; i++) if (req[i]) return i;
    end
    for (int k = 1; k <= N; k++) if (req[(ptr[c] + k) % N]) return (ptr[c] + k) % N;
    return -1;
  endfunction

  task automatic grant_to(input int c, input int w);
    if (owner[c] >= 0 && w >= 0 && w != owner[c]) n_hand++;
    owner[c] = w;
    if (w >= 0) ptr[c] = w;
    wd[c] = 0;
  endtask

  // Advance one clock edge using the inputs present at that edge.
  task automatic step(input int c);
    int  o;
    bit  term;
    o    = owner[c];
    term = s_ack | s_err | s_rty;
    if (o < 0) begin
      grant_to(c, pick(c, m_cyc));
    end else if (abrt[c]) begin
      abrt[c] = 1'b0;
      if (!m_cyc[o]) grant_to(c, pick(c, m_cyc));
    end else if (!m_cyc[o]) begin
      grant_to(c, pick(c, m_cyc));
    end else if (TMO[c] > 0 && m_stb[o] && !term) begin
      wd[c]++;
      if (wd[c] == TMO[c]) begin
        abrt[c] = 1'b1;
        wd[c] = 0;
        if (c == 0) n_tmo++;
      end
    end else if (term) begin
      wd[c] = 0;
    end
  endtask

  function automatic obs_t expect_obs(input int c);
    obs_t e;
    int   o;
    e       = '0;
    e.m_dat = s_dat;
    o       = owner[c];
    if (o >= 0) begin
      e.grant[o] = 1'b1;
      e.s_adr    = m_adr[o];
      e.s_dat    = m_dat[o];
      e.s_sel    = m_sel[o];
      e.s_cti    = m_cti[o];
      e.s_bte    = m_bte[o];
      e.s_we     = m_we[o];
      if (abrt[c]) begin
        e.err[o] = 1'b1;
        e.tmo    = 1'b1;
      end else begin
        e.s_cyc  = m_cyc[o];
        e.s_stb  = m_cyc[o] & m_stb[o];
        e.ack[o] = s_ack;
        e.err[o] = s_err;
        e.rty[o] = s_rty;
      end
    end
    return e;
  endfunction

  task automatic compare(input int c);
    obs_t  e, g;
    string p;
    e = expect_obs(c);
    g = obs[c];
    p = (c == 0) ? "rr" : "fx";
    chk({p, " grant"}, 64'(g.grant), 64'(e.grant));
    chk({p, " ack"},   64'(g.ack),   64'(e.ack));
    chk({p, " err"},   64'(g.err),   64'(e.err));
    chk({p, " rty"},   64'(g.rty),   64'(e.rty));
    chk({p, " tmo"},   64'(g.tmo),   64'(e.tmo));
    chk({p, " s_cyc"}, 64'(g.s_cyc), 64'(e.s_cyc));
    chk({p, " s_stb"}, 64'(g.s_stb), 64'(e.s_stb));
    chk({p, " s_we"},  64'(g.s_we),  64'(e.s_we));
    chk({p, " s_adr"}, 64'(g.s_adr), 64'(e.s_adr));
    chk({p, " s_dat"}, 64'(g.s_dat), 64'(e.s_dat));
    chk({p, " s_sel"}, 64'(g.s_sel), 64'(e.s_sel));
    chk({p, " s_cti"}, 64'(g.s_cti), 64'(e.s_cti));
    chk({p, " s_bte"}, 64'(g.s_bte), 64'(e.s_bte));
    chk({p, " m_dat"}, 64'(g.m_dat), 64'(e.m_dat));
  endtask

  // pt: 1-in-pt chance of a slave termination each cycle.
  // pd: 1-in-pd chance that a requesting master drops CYC.
  task automatic drive(input int pt, input int pd);
    for (int k = 0; k < N; k++) begin
      if (m_cyc[k]) begin
        if ($urandom_range(pd - 1) == 0) m_cyc[k] = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        m_cyc[k] = 1'b1;
      end
      m_stb[k] = ($urandom_range(3) != 0);
      m_adr[k] = AW'($urandom);
      m_dat[k] = $urandom;
      m_sel[k] = SW'($urandom);
      m_cti[k] = 3'($urandom);
      m_bte[k] = 2'($urandom);
      m_we[k]  = 1'($urandom);
    end
    s_dat = $urandom;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    if ($urandom_range(pt - 1) == 0) begin
      case ($urandom_range(2))
        0: s_ack = 1'b1;
        1: s_err = 1'b1;
        default: s_rty = 1'b1;
      endcase
    end
  endtask

  task automatic run(input int cycles, input int pt, input int pd);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      if (rst_n) begin
        step(0);
        step(1);
      end
      #1 drive(pt, pd);
      @(negedge clk);
      compare(0);
      compare(1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m_adr = '0; m_dat = '0; m_sel = '0; m_cti = '0; m_bte = '0;
    m_we = '0; m_stb = '0; m_cyc = '0;
    s_dat = 32'hDEADBEEF; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    model_reset();
    #2;
    compare(0);
    compare(1);

    // Simultaneous requests straight after reset.
    @(negedge clk);
    m_cyc = '1; m_stb = '1;
    rst_n = 1'b1;
    run(600, 3, 8);    // busy slave, frequent handovers
    run(800, 40, 30);  // slave mostly silent, so the watchdog fires

    // Asynchronous reset in the middle of traffic.
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare(0);
    compare(1);
    @(negedge clk);
    compare(0);
    compare(1);
    m_cyc = '1;
    rst_n = 1'b1;
    run(400, 5, 4);

    if (n_tmo == 0) chk("watchdog_exercised", 64'(n_tmo), 64'(1));
    if (n_hand == 0) chk("handover_exercised", 64'(n_hand), 64'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_cpu_bus_arbiter.md
Name: wb_cpu_bus_arbiter

Overview:
- Parametrised Wishbone B3 arbiter that merges NUM_MASTERS CPU-side master ports onto one shared slave port.
- Typical use: instruction and data buses of the wishbone_cpu instance, plus optional debug or DMA masters, feeding the SoC interconnect.
- Supports round-robin or fixed priority arbitration.
- Includes a per-transfer bus watchdog that terminates hung cycles with ERR.

Parameters:
- NUM_MASTERS, 2, number of master ports (1..8).
- ADDRESS_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; SEL width is DATA_WIDTH/8.
- PRIORITY_MODE, 0, 0 = round-robin; 1 = fixed, lowest index wins.
- TIMEOUT_CYCLES, 255, cycles of STB without ACK/ERR/RTY before forced ERR; 0 disables the watchdog.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-low
- m_adr_i  in  NUM_MASTERS*ADDRESS_WIDTH  master addresses, master k at slice k
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  master write data
- m_sel_i  in  NUM_MASTERS*DATA_WIDTH/8  byte selects
- m_cti_i  in  NUM_MASTERS*3  cycle type
- m_bte_i  in  NUM_MASTERS*2  burst type
- m_we_i, m_stb_i, m_cyc_i  in  NUM_MASTERS each  per-master WE/STB/CYC
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters
- m_ack_o, m_err_o, m_rty_o  out  NUM_MASTERS each  per-master termination
- s_adr_o  out  ADDRESS_WIDTH  slave address
- s_dat_o  out  DATA_WIDTH  slave write data
- s_sel_o  out  DATA_WIDTH/8  slave byte selects
- s_cti_o  out  3  slave cycle type
- s_bte_o  out  2  slave burst type
- s_we_o, s_stb_o, s_cyc_o  out  1 each  slave WE/STB/CYC
- s_dat_i  in  DATA_WIDTH  slave read data
- s_ack_i, s_err_i, s_rty_i  in  1 each  slave termination
- grant_o  out  NUM_MASTERS  one-hot current owner, registered
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (rst_i low, async): state IDLE, grant_o=0, RR pointer=0, watchdog=0, timeout_o=0.
  - All s_* outputs are 0 while grant is 0.
  - m_ack_o, m_err_o and m_rty_o are all 0.
- States: IDLE, OWNED, ABORT.
- IDLE: if any m_cyc_i is high, the winner is registered into grant_o at the edge and the state goes to OWNED.
  - Slave CYC appears 1 cycle after request (fixed latency).
- Winner selection:
  - Round-robin: search starts at index (ptr+1) mod NUM_MASTERS; ptr updates to the winner on grant.
  - Fixed: lowest requesting index.
- OWNED:
  - s_adr/dat/sel/cti/bte/we/stb/cyc are combinationally muxed from the granted master.
  - s_ack/err/rty_i are routed only to the granted master's m_*_o; other masters see 0.
  - m_dat_o = s_dat_i unconditionally.
- Grant is held while the owner keeps m_cyc_i high. Bursts and back-to-back STB are never interrupted (lock semantics).
- Owner drops m_cyc_i:
  - At that edge, re-arbitrate among the other requesters, excluding the releasing master under round-robin if others request.
  - If a winner exists, hand over directly with no idle cycle. Otherwise go to IDLE, grant_o=0.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counts edges in OWNED with s_stb_o=1 and no s_ack_i/s_err_i/s_rty_i.
  - Cleared by any termination, by owner change, or in IDLE.
  - When the count reaches TIMEOUT_CYCLES, go to ABORT.
- ABORT (1 cycle):
  - s_cyc_o=s_stb_o=0; m_err_o[owner]=1; timeout_o=1; watchdog cleared.
  - Next state is OWNED if the owner still holds CYC, else arbitrate as above.
- A slave termination arriving in the ABORT cycle is discarded.
- Simultaneous requests resolve per PRIORITY_MODE in the same edge; no two grant bits are ever set.
- NUM_MASTERS=1: grant is always bit 0 when CYC is high; the watchdog is unchanged.
- Reset asserted mid-transfer: all outputs go to reset values immediately. Transfer state is lost, with no ERR pulse.
- TIMEOUT_CYCLES=0: the watchdog and ABORT state are unreachable; timeout_o stays 0.

Test Plan:
- Single master 0 read, adr 0x1000, slave ACKs 2 cycles after STB with dat 0xDEADBEEF -> s_cyc_o high 1 cycle after m_cyc_i[0]; m_ack_o=01 for 1 cycle; m_dat_o=0xDEADBEEF; grant_o=01.
- RR, NUM_MASTERS=2, both CYC high at the same edge after reset -> master 1 wins first (ptr=0). On its release, master 0 is granted in the next cycle with no IDLE gap. grant_o sequence 10, 01.
- Fixed priority, 3 masters, master 2 owns a 4-beat burst (cti 010 then 111), master 0 requests mid-burst -> all 4 beats complete to master 2; master 0 is granted the cycle after master 2 drops CYC.
- TIMEOUT_CYCLES=8, slave never ACKs -> after 8 STB cycles: timeout_o=1, m_err_o[owner]=1, and s_cyc_o=0 for exactly 1 cycle. Watchdog restarts from 0 if STB persists.
- Slave returns s_err_i and s_rty_i on separate transfers -> only the owner's m_err_o / m_rty_o pulses; non-owner terminations stay 0.
- rst_i driven low mid-burst -> s_cyc_o, grant_o and all m_*_o go to 0 asynchronously. After release, the first request is granted per PRIORITY_MODE with ptr=0.
